// File: rtl/qoi_pkg.sv
// rtl/qoi_pkg.sv - shared QOI framer types, constants and header byte lookup
package qoi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_BODY    = 2'd2,
      ST_TRAILER = 2'd3
   } state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic [7:0] a;
   } rgba_t;

   localparam logic [31:0] QOI_MAGIC       = 32'h716F6966;
   localparam int          HEADER_LEN      = 14;
   localparam int          TRAILER_LEN     = 8;
   localparam int          MAX_CHUNK_BYTES = 5;

   // Header byte idx of magic, width, height, channels=4, colorspace=0.
   function automatic logic [7:0] header_byte(input logic [3:0]  idx,
                                              input logic [31:0] width,
                                              input logic [31:0] height);
      logic [111:0] hdr;
      logic [111:0] shifted;
      hdr     = {QOI_MAGIC, width, height, 8'h04, 8'h00};
      shifted = hdr << {idx, 3'b000};
      return shifted[111:104];
   endfunction

endpackage

// File: rtl/qoi_stream_framer_if.sv
// rtl/qoi_stream_framer_if.sv - chunk input and byte output handshake bundle
interface qoi_stream_framer_if;
   logic [39:0] in_data;
   logic [2:0]  in_count;
   logic        in_last;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   modport master (
      output in_data, in_count, in_last, out_ready,
      input  out_byte, out_valid, out_last
   );

   modport slave (
      input  in_data, in_count, in_last, out_ready,
      output out_byte, out_valid, out_last
   );
endinterface

// File: rtl/byte_fifo_multiwrite.sv
// rtl/byte_fifo_multiwrite.sv - byte FIFO with up to 5-byte write, 1-byte read
module byte_fifo_multiwrite #(
   parameter int   DEPTH = 16,
   localparam int  AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [39:0]   wr_data,
   input  logic [2:0]    wr_count,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic [AW:0]   occupancy
);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_occ;
   logic [AW:0]   w_inc;
   logic [AW:0]   w_dec;

   assign w_inc     = wr_en ? (AW+1)'(wr_count) : '0;
   assign w_dec     = {{AW{1'b0}}, rd_en};
   assign rd_data   = r_mem[r_rd_ptr];
   assign occupancy = r_occ;

   // Byte [4] of the group lands at the current write pointer, later bytes follow.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 5; i++) begin
            if (3'(i) < wr_count) begin
               r_mem[r_wr_ptr + AW'(i)] <= wr_data[8*(4-i) +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(wr_count);
         end
         if (rd_en) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_occ <= r_occ + w_inc - w_dec;
      end
   end

endmodule

// File: rtl/qoi_stream_framer.sv
// rtl/qoi_stream_framer.sv - wraps qoi_core chunk groups into a QOI byte stream
module qoi_stream_framer
   import qoi_pkg::*;
#(
   parameter int WIDTH      = 40,
   parameter int HEIGHT     = 30,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   qoi_stream_framer_if.slave   bus,
   output logic                 busy,
   output logic                 overflow,
   output logic [12:0]          byte_total
);

   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);

   state_t      r_state;
   logic [3:0]  r_idx;
   logic [7:0]  r_out_byte;
   logic        r_out_valid;
   logic        r_out_last;
   logic        r_busy;
   logic        r_overflow;
   logic        r_last_cap;
   logic [12:0] r_byte_total;

   logic        w_xfer;
   logic        w_load;
   logic [2:0]  w_cnt;
   logic        w_accept;
   logic        w_fit;
   logic        w_wr_en;
   logic        w_rd_en;
   logic [AW:0] w_occ;
   logic [AW:0] w_free;
   logic [7:0]  w_fifo_byte;
   logic [7:0]  w_hdr_byte;

   assign w_xfer   = r_out_valid & bus.out_ready;
   assign w_load   = ~r_out_valid | bus.out_ready;
   assign w_cnt    = (bus.in_count > 3'(MAX_CHUNK_BYTES)) ? 3'd0 : bus.in_count;
   assign w_accept = ((r_state == ST_HEADER) || (r_state == ST_BODY)) && !r_last_cap;
   // Admission sees only start-of-cycle occupancy; a same-cycle read earns no credit.
   assign w_free   = DEPTH_W - w_occ;
   assign w_fit    = (AW+1)'(w_cnt) <= w_free;
   assign w_wr_en  = w_accept && w_fit && (w_cnt != 3'd0);
   assign w_rd_en  = (r_state == ST_BODY) && w_load && (w_occ != '0);
   assign w_hdr_byte = header_byte(r_idx, 32'(WIDTH), 32'(HEIGHT));

   assign bus.out_byte  = r_out_byte;
   assign bus.out_valid = r_out_valid;
   assign bus.out_last  = r_out_last;
   assign busy          = r_busy;
   assign overflow      = r_overflow;
   assign byte_total    = r_byte_total;

   byte_fifo_multiwrite #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (w_wr_en),
      .wr_data   (bus.in_data),
      .wr_count  (w_cnt),
      .rd_en     (w_rd_en),
      .rd_data   (w_fifo_byte),
      .occupancy (w_occ)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_out_byte   <= '0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_busy       <= 1'b0;
         r_overflow   <= 1'b0;
         r_last_cap   <= 1'b0;
         r_byte_total <= '0;
      end else begin
         if (w_xfer && (r_byte_total != 13'h1FFF)) begin
            r_byte_total <= r_byte_total + 13'd1;
         end
         if (w_accept) begin
            if (!w_fit) begin
               r_overflow <= 1'b1;
            end
            if (bus.in_last) begin
               r_last_cap <= 1'b1;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state      <= ST_HEADER;
                  r_busy       <= 1'b1;
                  r_out_valid  <= 1'b1;
                  r_out_byte   <= QOI_MAGIC[31:24];
                  r_out_last   <= 1'b0;
                  r_idx        <= 4'd1;
                  r_byte_total <= '0;
                  r_overflow   <= 1'b0;
                  r_last_cap   <= 1'b0;
               end
            end
            ST_HEADER: begin
               if (w_xfer) begin
                  if (r_idx == 4'(HEADER_LEN)) begin
                     r_out_valid <= 1'b0;
                     r_state     <= ST_BODY;
                  end else begin
                     r_out_byte <= w_hdr_byte;
                     r_idx      <= r_idx + 4'd1;
                  end
               end
            end
            ST_BODY: begin
               // Drain buffered chunk bytes first; the trailer starts only once empty.
               if (w_load) begin
                  if (w_occ != '0) begin
                     r_out_byte  <= w_fifo_byte;
                     r_out_valid <= 1'b1;
                  end else if (r_last_cap) begin
                     r_state     <= ST_TRAILER;
                     r_out_byte  <= 8'h00;
                     r_out_valid <= 1'b1;
                     r_idx       <= 4'd1;
                  end else begin
                     r_out_valid <= 1'b0;
                  end
               end
            end
            ST_TRAILER: begin
               if (w_xfer) begin
                  if (r_idx == 4'(TRAILER_LEN)) begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_busy      <= 1'b0;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_out_byte <= (r_idx == 4'(TRAILER_LEN - 1)) ? 8'h01 : 8'h00;
                     r_out_last <= (r_idx == 4'(TRAILER_LEN - 1));
                     r_idx      <= r_idx + 4'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qoi_stream_framer.sv
// tb/tb_qoi_stream_framer.sv - directed self-checking bench for qoi_stream_framer
module tb_qoi_stream_framer;

   logic        clk = 1'b0;
   logic        t_reset = 1'b1;
   logic        t_start = 1'b0;
   logic [39:0] t_in_data = '0;
   logic [2:0]  t_in_count = '0;
   logic        t_in_last = 1'b0;
   logic        t_ready = 1'b0;
   logic        sel = 1'b0;
   int          ready_mode = 1;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   logic        busy0, ovf0, busy8, ovf8;
   logic [12:0] tot0, tot8;

   logic [7:0]  got[$];
   logic        got_last[$];
   logic [7:0]  exp_q[$];

   qoi_stream_framer_if if0 ();
   qoi_stream_framer_if if8 ();

   assign if0.in_data = t_in_data;  assign if8.in_data = t_in_data;
   assign if0.in_count = t_in_count; assign if8.in_count = t_in_count;
   assign if0.in_last = t_in_last;  assign if8.in_last = t_in_last;
   assign if0.out_ready = t_ready;  assign if8.out_ready = t_ready;

   qoi_stream_framer u_dut (
      .clk (clk), .reset (t_reset), .start (t_start & ~sel), .bus (if0),
      .busy (busy0), .overflow (ovf0), .byte_total (tot0)
   );

   qoi_stream_framer #(.FIFO_DEPTH (8)) u_dut8 (
      .clk (clk), .reset (t_reset), .start (t_start & sel), .bus (if8),
      .busy (busy8), .overflow (ovf8), .byte_total (tot8)
   );

   logic [7:0]  obs_byte;
   logic        obs_valid, obs_last, obs_busy, obs_ovf;
   logic [12:0] obs_total;
   assign obs_byte  = sel ? if8.out_byte  : if0.out_byte;
   assign obs_valid = sel ? if8.out_valid : if0.out_valid;
   assign obs_last  = sel ? if8.out_last  : if0.out_last;
   assign obs_busy  = sel ? busy8 : busy0;
   assign obs_ovf   = sel ? ovf8  : ovf0;
   assign obs_total = sel ? tot8  : tot0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      logic       stalled;
      logic [7:0] hold_byte;
      logic       hold_last;
      if (ready_mode == 0)      t_ready = 1'b0;
      else if (ready_mode == 1) t_ready = 1'b1;
      else                      t_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      stalled   = obs_valid && !t_ready && !t_reset;
      hold_byte = obs_byte;
      hold_last = obs_last;
      if (obs_valid && t_ready && !t_reset) begin
         got.push_back(obs_byte);
         got_last.push_back(obs_last);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (stalled) begin
         check("stall_valid", 32'(obs_valid), 32'd1);
         check("stall_byte", 32'(obs_byte), 32'(hold_byte));
         check("stall_last", 32'(obs_last), 32'(hold_last));
      end
   endtask

   task automatic clear_in();
      t_in_data = '0; t_in_count = '0; t_in_last = 1'b0; t_start = 1'b0;
   endtask

   task automatic group(input logic [39:0] d, input logic [2:0] c, input logic l);
      t_in_data = d; t_in_count = c; t_in_last = l;
      step();
      clear_in();
   endtask

   task automatic begin_frame();
      got.delete(); got_last.delete(); exp_q.delete();
      t_start = 1'b1;
      step();
      t_start = 1'b0;
      check("first_valid", 32'(obs_valid), 32'd1);
      check("first_byte", 32'(obs_byte), 32'h71);
   endtask

   task automatic run_frame();
      int n = 0;
      while (obs_busy && n < 400) begin
         step();
         n++;
      end
      check("frame_done", 32'(obs_busy), 32'd0);
   endtask

   task automatic add_hdr();
      logic [7:0] h [14] = '{8'h71, 8'h6F, 8'h69, 8'h66, 8'h00, 8'h00, 8'h00, 8'h28,
                             8'h00, 8'h00, 8'h00, 8'h1E, 8'h04, 8'h00};
      for (int i = 0; i < 14; i++) exp_q.push_back(h[i]);
   endtask

   task automatic add_trl();
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h00);
      exp_q.push_back(8'h01);
   endtask

   task automatic compare_seq(input string tag);
      check({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
         check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == exp_q.size() - 1));
      end
   endtask

   initial begin
      ready_mode = 1;
      step(); step();
      t_start = 1'b1;
      step();
      t_start = 1'b0;
      t_reset = 1'b0;
      check("rst_valid", 32'(obs_valid), 32'd0);
      check("rst_busy", 32'(obs_busy), 32'd0);
      check("rst_ovf", 32'(obs_ovf), 32'd0);
      check("rst_total", 32'(obs_total), 32'd0);
      check("rst_last", 32'(obs_last), 32'd0);
      check("rst_byte", 32'(obs_byte), 32'd0);

      // single FE byte; in_count=7 group must be treated as empty
      begin_frame();
      group(40'hAABBCCDDEE, 3'd7, 1'b0);
      group(40'hFE00000000, 3'd1, 1'b1);
      run_frame();
      add_hdr(); exp_q.push_back(8'hFE); add_trl();
      compare_seq("s1");
      check("s1_total", 32'(obs_total), 32'd23);
      check("s1_busy", 32'(obs_busy), 32'd0);
      check("s1_ovf", 32'(obs_ovf), 32'd0);

      // three full groups during HEADER; start mid-frame is ignored
      begin_frame();
      group(40'h0102030405, 3'd5, 1'b0);
      t_start = 1'b1;
      group(40'h060708090A, 3'd5, 1'b0);
      group(40'h0B0C0D0E0F, 3'd5, 1'b1);
      run_frame();
      add_hdr();
      for (int i = 1; i <= 15; i++) exp_q.push_back(8'(i));
      add_trl();
      compare_seq("s2");
      check("s2_ovf", 32'(obs_ovf), 32'd0);
      check("s2_total", 32'(obs_total), 32'd37);

      // depth 8, stalled output: second group dropped
      sel = 1'b1;
      ready_mode = 0;
      got.delete(); got_last.delete(); exp_q.delete();
      t_start = 1'b1;
      step();
      t_start = 1'b0;
      check("s3_first_byte", 32'(obs_byte), 32'h71);
      group(40'h1112131415, 3'd5, 1'b0);
      check("s3_ovf_before", 32'(obs_ovf), 32'd0);
      group(40'h2122232425, 3'd5, 1'b1);
      check("s3_ovf", 32'(obs_ovf), 32'd1);
      ready_mode = 1;
      run_frame();
      add_hdr();
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h11 + 8'(i));
      add_trl();
      compare_seq("s3");
      check("s3_total", 32'(obs_total), 32'd27);
      check("s3_ovf_sticky", 32'(obs_ovf), 32'd1);
      sel = 1'b0;

      // ready pattern 1,0,0,1 with stall stability checks
      ready_mode = 2;
      cyc = 0;
      begin_frame();
      group(40'hA0A1A2A3A4, 3'd5, 1'b0);
      group(40'hA5A6A70000, 3'd3, 1'b0);
      group(40'hA800000000, 3'd1, 1'b1);
      run_frame();
      add_hdr();
      for (int i = 0; i < 9; i++) exp_q.push_back(8'hA0 + 8'(i));
      add_trl();
      compare_seq("s4");
      check("s4_total", 32'(obs_total), 32'd31);
      ready_mode = 1;

      // empty body
      begin_frame();
      group(40'h0, 3'd0, 1'b1);
      run_frame();
      add_hdr(); add_trl();
      compare_seq("s5");
      check("s5_total", 32'(obs_total), 32'd22);

      // reset after 5 header bytes, then restart
      begin_frame();
      for (int n = 0; n < 20 && got.size() < 5; n++) step();
      check("s6_five", got.size(), 32'd5);
      t_reset = 1'b1;
      step();
      t_reset = 1'b0;
      check("s6_valid", 32'(obs_valid), 32'd0);
      check("s6_busy", 32'(obs_busy), 32'd0);
      check("s6_total", 32'(obs_total), 32'd0);
      begin_frame();
      group(40'h0, 3'd0, 1'b1);
      run_frame();
      add_hdr(); add_trl();
      compare_seq("s6");
      check("s6_total_end", 32'(obs_total), 32'd22);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
